// File: rtl/task_map_pkg.sv
// Shared types and sizing helpers for the task-graph sequencer and the task mapper.
package task_map_pkg;

    localparam int TM_NUM_V  = 4;
    localparam int TM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } tseq_state_t;

    function automatic int addr_w(input int nv);
        return (nv * nv > 1) ? $clog2(nv * nv) : 1;
    endfunction

    function automatic int rc_w(input int nv);
        return (nv > 1) ? $clog2(nv) : 1;
    endfunction

    function automatic int cnt_w(input int nv);
        return $clog2(nv * nv + 1);
    endfunction

endpackage

// File: rtl/tg_index_counter.sv
// Row-major row/col walker over an NUM_V x NUM_V matrix; o_last flags the final entry.
module tg_index_counter
    import task_map_pkg::*;
#(
    parameter int NUM_V = TM_NUM_V,
    parameter int RCW   = rc_w(NUM_V)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [RCW-1:0] o_row,
    output logic [RCW-1:0] o_col,
    output logic           o_last
);

    localparam logic [RCW-1:0] MAX_IDX = RCW'(NUM_V - 1);
    localparam logic [RCW-1:0] ONE     = RCW'(1);

    logic [RCW-1:0] r_row;
    logic [RCW-1:0] r_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (r_col == MAX_IDX) begin
                r_col <= '0;
                r_row <= (r_row == MAX_IDX) ? '0 : r_row + ONE;
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == MAX_IDX) && (r_col == MAX_IDX);

endmodule

// File: rtl/task_graph_sequencer.sv
// Streams an adjacency matrix from synchronous-read memory to the task mapper.
// Define TASK_SEQ_SKIP_ZERO_EN to drop zero-weight entries instead of issuing them.
module task_graph_sequencer
    import task_map_pkg::*;
#(
    parameter int NUM_V  = TM_NUM_V,
    parameter int DATA_W = TM_DATA_W,
    parameter int AW     = addr_w(NUM_V),
    parameter int RCW    = rc_w(NUM_V),
    parameter int CW     = cnt_w(NUM_V)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] task_array,
    output logic [RCW-1:0]    row,
    output logic [RCW-1:0]    col,
    output logic              task_valid,
    input  logic              task_ready,
    output logic              root_task,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     edge_count,
    output tseq_state_t       o_dbg_state
);

    // Handshake: an entry transfers on a rising edge where task_valid && task_ready;
    // task_array/row/col/root_task stay stable while task_valid waits for task_ready.

    tseq_state_t       r_state;
    logic              r_found;
    logic              r_mem_rd_en;
    logic              r_task_valid;
    logic              r_root_task;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_task_array;
    logic [CW-1:0]     r_edge_count;

    logic              w_clear;
    logic              w_advance;
    logic              w_last;
    logic              w_xfer;
    logic              w_rd_nonzero;
    logic [RCW-1:0]    w_row;
    logic [RCW-1:0]    w_col;

    assign w_clear      = (r_state == IDLE) && start;
    assign w_xfer       = (r_state == ISSUE) && task_ready;
    assign w_rd_nonzero = |mem_rd_data;
`ifdef TASK_SEQ_SKIP_ZERO_EN
    assign w_advance    = w_xfer || ((r_state == WAIT) && !w_rd_nonzero);
`else
    assign w_advance    = w_xfer;
`endif

    tg_index_counter #(
        .NUM_V (NUM_V),
        .RCW   (RCW)
    ) u_index (
        .i_clk     (clk),
        .i_rst     (rst_b),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state      <= IDLE;
            r_found      <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_task_valid <= 1'b0;
            r_root_task  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_task_array <= '0;
            r_edge_count <= '0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_edge_count <= '0;
                        r_found      <= 1'b0;
                        r_mem_rd_en  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                FETCH: r_state <= WAIT;
                WAIT: begin
                    r_task_array <= mem_rd_data;
                    if (w_rd_nonzero) begin
                        r_edge_count <= r_edge_count + CW'(1);
                    end
`ifdef TASK_SEQ_SKIP_ZERO_EN
                    if (!w_rd_nonzero) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_state     <= FETCH;
                        end
                    end else begin
                        r_task_valid <= 1'b1;
                        r_root_task  <= !r_found;
                        r_state      <= ISSUE;
                    end
`else
                    r_task_valid <= 1'b1;
                    r_root_task  <= w_rd_nonzero && !r_found;
                    r_state      <= ISSUE;
`endif
                end
                ISSUE: begin
                    if (task_ready) begin
                        r_task_valid <= 1'b0;
                        r_root_task  <= 1'b0;
                        if (|r_task_array) begin
                            r_found <= 1'b1;
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = AW'(int'(w_row) * NUM_V + int'(w_col));
    assign task_array  = r_task_array;
    assign row         = w_row;
    assign col         = w_col;
    assign task_valid  = r_task_valid;
    assign root_task   = r_root_task;
    assign busy        = r_busy;
    assign done        = r_done;
    assign edge_count  = r_edge_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_task_graph_sequencer.sv
// Randomized bench for task_graph_sequencer against a row-major reference model.
module tb_task_graph_sequencer;
    import task_map_pkg::*;

    localparam int NV   = 4;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int RCW  = 2;
    localparam int CW   = 5;
    localparam int NE   = NV * NV;
    localparam int MAXK = 256;
    localparam int EW   = 1 + 2 * RCW + DW;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              start;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rd_data = '0;
    logic [DW-1:0]     task_array;
    logic [RCW-1:0]    row;
    logic [RCW-1:0]    col;
    logic              task_valid;
    logic              task_ready;
    logic              root_task;
    logic              busy;
    logic              done;
    logic [CW-1:0]     edge_count;
    tseq_state_t       dbg_state;

    always #5 clk = ~clk;

    task_graph_sequencer dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .task_array  (task_array),
        .row         (row),
        .col         (col),
        .task_valid  (task_valid),
        .task_ready  (task_ready),
        .root_task   (root_task),
        .busy        (busy),
        .done        (done),
        .edge_count  (edge_count),
        .o_dbg_state (dbg_state)
    );

    // graph storage with one-cycle read latency
    logic [DW-1:0] mem_tb [NE];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_tb[mem_addr];
    end

    typedef struct {
        logic           valid, ready, root, done, busy, rd_en;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  val;
        logic [RCW-1:0] row, col;
        logic [CW-1:0]  ecnt;
        tseq_state_t    st;
    } snap_t;

    snap_t         snap [MAXK];
    int            n_snap;
    int            stall_tb [NE];
    logic [EW-1:0] exp_q [$];
    int            exp_edges;
    int            exp_done;
    int            total = 0;
    int            bad   = 0;

    // Reference: walk the matrix row-major, deciding per entry whether it is issued,
    // whether it is the pass root, and how many cycles it costs.
    task automatic build_model();
        logic found;
        logic issue;
        found     = 1'b0;
        exp_edges = 0;
        exp_done  = 1;
        exp_q.delete();
        for (int p = 0; p < NE; p++) begin
            logic [DW-1:0] v;
            logic          rt;
            v = mem_tb[p];
            if (v != 0) exp_edges++;
`ifdef TASK_SEQ_SKIP_ZERO_EN
            issue = (v != 0);
`else
            issue = 1'b1;
`endif
            if (issue) begin
                rt = (v != 0) && !found;
                if (v != 0) found = 1'b1;
                exp_q.push_back({rt, 2'(p / NV), 2'(p % NV), v});
                exp_done += 3 + stall_tb[p];
            end else begin
                exp_done += 2;
            end
        end
    endtask

    // Runs one pass starting at relative cycle 0 and records a negedge snapshot per cycle.
    task automatic run_pass(input int start2_at, input int rst_at, input int max_k);
        int used [NE];
        int first_done;
        first_done = -1;
        n_snap     = 0;
        foreach (used[i]) used[i] = 0;
        for (int k = 0; k < max_k; k++) begin
            start = (k == 0) || (k == start2_at);
            rst_b = (k == rst_at);
            if (task_valid) begin
                int p;
                p = int'(row) * NV + int'(col);
                if (used[p] < stall_tb[p]) begin
                    task_ready = 1'b0;
                    used[p]++;
                end else begin
                    task_ready = 1'b1;
                end
            end else begin
                task_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            snap[k].valid = task_valid;
            snap[k].ready = task_ready;
            snap[k].root  = root_task;
            snap[k].done  = done;
            snap[k].busy  = busy;
            snap[k].rd_en = mem_rd_en;
            snap[k].addr  = mem_addr;
            snap[k].val   = task_array;
            snap[k].row   = row;
            snap[k].col   = col;
            snap[k].ecnt  = edge_count;
            snap[k].st    = dbg_state;
            n_snap = k + 1;
            if (done && first_done < 0) first_done = k;
            @(posedge clk);
            #1;
            if (first_done >= 0 && k >= first_done + 4) break;
        end
        start      = 1'b0;
        rst_b      = 1'b0;
        task_ready = 1'b1;
    endtask

    task automatic load_spec_mem();
        logic [DW-1:0] spec_vals [NE];
        spec_vals = '{0, 5, 0, 7, 5, 0, 6, 0, 0, 6, 0, 0, 7, 0, 0, 0};
        foreach (mem_tb[i]) begin
            mem_tb[i]   = spec_vals[i];
            stall_tb[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst_b      = 1'b1;
        start      = 1'b1;
        task_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({task_valid, root_task, done, busy, mem_rd_en, mem_addr, task_array, row, col, edge_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {task_valid, root_task, done, busy, mem_rd_en, mem_addr, task_array, row, col, edge_count});
        end
        total++;
        if (dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
        end
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_passes();
        for (int sc = 0; sc < 12; sc++) begin
            int s2;
            int ndone;
            int dk;
            s2 = -1;
            load_spec_mem();
            if (sc == 1) stall_tb[1] = 4;
            if (sc == 2) foreach (mem_tb[i]) mem_tb[i] = '0;
            if (sc == 3) s2 = 10;
            if (sc >= 4) begin
                foreach (mem_tb[i]) begin
                    if ($urandom_range(0, 1) == 0) mem_tb[i] = '0;
                    else if ($urandom_range(0, 3) == 0) mem_tb[i] = 32'h1 << $urandom_range(0, 31);
                    else mem_tb[i] = $urandom;
                    stall_tb[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                end
            end
            build_model();
            run_pass(s2, -1, MAXK);
            ndone = 0;
            dk    = -1;
            for (int k = 0; k < n_snap; k++) begin
                if (snap[k].done) begin
                    ndone++;
                    if (dk < 0) dk = k;
                end
                total++;
                if (snap[k].valid) begin
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sc%0d extra_entry k=%0d got row=%0d col=%0d val=%h want none",
                                 sc, k, snap[k].row, snap[k].col, snap[k].val);
                    end else begin
                        logic [EW-1:0] got;
                        got = {snap[k].root, snap[k].row, snap[k].col, snap[k].val};
                        if (got !== exp_q[0]) begin
                            bad++;
                            $display("FAIL sc%0d entry k=%0d got root/row/col/val=%h want %h",
                                     sc, k, got, exp_q[0]);
                        end
                        if (snap[k].ready) void'(exp_q.pop_front());
                    end
                end else if (snap[k].root !== 1'b0) begin
                    bad++;
                    $display("FAIL sc%0d root_without_valid k=%0d got=%b want=0", sc, k, snap[k].root);
                end
            end
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL sc%0d missing_entries got_left=%0d want=0", sc, exp_q.size());
            end
            total++;
            if (ndone != 1) begin
                bad++;
                $display("FAIL sc%0d done_count got=%0d want=1", sc, ndone);
            end
            total++;
            if (dk != exp_done) begin
                bad++;
                $display("FAIL sc%0d done_cycle got=%0d want=%0d", sc, dk, exp_done);
            end
            total++;
            if ({snap[1].rd_en, snap[1].addr, snap[1].busy} !== {1'b1, 4'd0, 1'b1}) begin
                bad++;
                $display("FAIL sc%0d first_fetch got rd_en=%b addr=%0d busy=%b want 1 0 1",
                         sc, snap[1].rd_en, snap[1].addr, snap[1].busy);
            end
            if (dk >= 0) begin
                total++;
                if (int'(snap[dk].ecnt) != exp_edges) begin
                    bad++;
                    $display("FAIL sc%0d edge_count got=%0d want=%0d", sc, snap[dk].ecnt, exp_edges);
                end
                total++;
                if (int'(snap[n_snap-1].ecnt) != exp_edges) begin
                    bad++;
                    $display("FAIL sc%0d edge_count_hold got=%0d want=%0d", sc, snap[n_snap-1].ecnt, exp_edges);
                end
                total++;
                if ({snap[dk].busy, snap[n_snap-1].busy, snap[n_snap-1].st} !== {1'b1, 1'b0, IDLE}) begin
                    bad++;
                    $display("FAIL sc%0d busy_end got busy_done=%b busy_after=%b st=%0d want 1 0 %0d",
                             sc, snap[dk].busy, snap[n_snap-1].busy, snap[n_snap-1].st, IDLE);
                end
            end
        end
    endtask

    task automatic test_mid_pass_reset();
        int ndone;
        int nxfer;
        int dk;
        load_spec_mem();
        run_pass(-1, 20, 30);
        ndone = 0;
        for (int k = 0; k < n_snap; k++) if (snap[k].done) ndone++;
        total++;
        if (snap[20].ecnt !== 5'd3) begin
            bad++;
            $display("FAIL midrst_count_before got=%0d want=3", snap[20].ecnt);
        end
        total++;
        if ({snap[21].valid, snap[21].root, snap[21].done, snap[21].busy, snap[21].rd_en,
             snap[21].addr, snap[21].val, snap[21].row, snap[21].col, snap[21].ecnt} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got=%h want=0",
                     {snap[21].valid, snap[21].root, snap[21].done, snap[21].busy, snap[21].rd_en,
                      snap[21].addr, snap[21].val, snap[21].row, snap[21].col, snap[21].ecnt});
        end
        total++;
        if (snap[21].st !== IDLE) begin
            bad++;
            $display("FAIL midrst_state got=%0d want=%0d", snap[21].st, IDLE);
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL midrst_no_done got=%0d want=0", ndone);
        end
        build_model();
        run_pass(-1, -1, MAXK);
        nxfer = 0;
        dk    = -1;
        for (int k = 0; k < n_snap; k++) begin
            if (snap[k].valid && snap[k].ready) nxfer++;
            if (snap[k].done && dk < 0) dk = k;
        end
        total++;
        if (nxfer != exp_q.size()) begin
            bad++;
            $display("FAIL midrst_fresh_xfers got=%0d want=%0d", nxfer, exp_q.size());
        end
        total++;
        if (dk != exp_done) begin
            bad++;
            $display("FAIL midrst_fresh_done got=%0d want=%0d", dk, exp_done);
        end
        total++;
        if (dk >= 0 && int'(snap[dk].ecnt) != exp_edges) begin
            bad++;
            $display("FAIL midrst_fresh_edges got=%0d want=%0d", snap[dk].ecnt, exp_edges);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b      = 1'b1;
        start      = 1'b0;
        task_ready = 1'b0;
        foreach (stall_tb[i]) stall_tb[i] = 0;
        foreach (mem_tb[i]) mem_tb[i] = '0;
        test_reset();
        test_passes();
        test_mid_pass_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
